// File: rtl/log2_stream_adapter.sv
// ----------------------------------------------------------------------------
// log2_stream_adapter
//
// Ready/valid wrapper around the fixed-latency log2 pipeline. Accepted FP32
// operands are registered into the unit, and every result the unit produces is
// caught in a first-word-fall-through output FIFO. The unit has no backpressure,
// so a credit pool the size of the FIFO limits how many operands can be in
// flight or buffered at once. This guarantees that every result has a free slot
// when it arrives.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/    operand stream in; a transfer happens when
//   s_data              s_valid & s_ready
//   m_valid/m_ready/    result stream out (FWFT, read latency 0)
//   m_data
//   unit_op, unit_vld_in, unit_en    drive the log2 unit
//   unit_result, unit_vld_out        return path from the log2 unit
//   ovf_err             sticky: a result arrived while the FIFO was full
//
// Optional build macro LOG2_ADAPTER_PERF_EN adds the following ports:
//   perf_clr     input; synchronous clear of both counters
//   perf_issued  output; count of accepted operands
//   perf_stall   output; count of cycles with s_valid & ~s_ready
// Both counters saturate at all-ones.
// ----------------------------------------------------------------------------
module log2_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,   // power of 2, >= 2
    parameter int unsigned PIPE_LAT   = 6    // only used by assertions
) (
    input  logic                  clk,
    input  logic                  rst,
    // operand stream
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    // result stream
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    // log2 unit interface
    output logic [DATA_WIDTH-1:0] unit_op,
    output logic                  unit_vld_in,
    output logic                  unit_en,
    input  logic [DATA_WIDTH-1:0] unit_result,
    input  logic                  unit_vld_out,
    // status
    output logic                  ovf_err
`ifdef LOG2_ADAPTER_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall
`endif
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned CredW = AddrW + 1;

    localparam logic [CredW-1:0] CredMax = CredW'(DEPTH);
    localparam logic [CredW-1:0] CredOne = CredW'(1);
    localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [CredW-1:0]      r_credit;
    logic [CredW-1:0]      w_credit_d;

    logic [DATA_WIDTH-1:0] r_unit_op;
    logic                  r_unit_vld_in;
    logic                  r_unit_en;
    logic                  r_ovf;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_wr_en;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_s_ready;

    // ------------------------------------------------------------------------
    // Credit pool: one credit per FIFO slot. A credit is consumed on issue and
    // returned on pop. With no same-cycle ready-through, a pop at zero credit
    // only reopens s_ready on the following cycle.
    // ------------------------------------------------------------------------
    assign w_s_ready = (r_credit != '0) & ~rst;
    assign w_issue   = s_valid & w_s_ready;

    always_comb begin
        w_credit_d = r_credit;
        if (w_issue && !w_pop) begin
            w_credit_d = r_credit - CredOne;
        end else if (!w_issue && w_pop) begin
            w_credit_d = r_credit + CredOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= CredMax;
        end else begin
            r_credit <= w_credit_d;
        end
    end

    // ------------------------------------------------------------------------
    // Issue register and unit enable
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unit_op     <= '0;
            r_unit_vld_in <= 1'b0;
            r_unit_en     <= 1'b0;
        end else begin
            r_unit_en     <= 1'b1;
            r_unit_vld_in <= w_issue;
            if (w_issue) begin
                r_unit_op <= s_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO. The pointers carry one extra wrap bit so that full and empty
    // can be told apart. Storage is reset so that m_data reads as zero while
    // the FIFO is empty after reset.
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);

    assign w_pop   = ~w_empty & m_ready;
    assign w_push  = unit_vld_out;
    // When the FIFO is full, a same-cycle pop frees the slot being written.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AddrW-1:0]] <= unit_result;
                r_wr_ptr                   <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            // The credit scheme should make this unreachable.
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_ready     = w_s_ready;
    assign m_valid     = ~w_empty;
    assign m_data      = r_mem[r_rd_ptr[AddrW-1:0]];
    assign unit_op     = r_unit_op;
    assign unit_vld_in = r_unit_vld_in;
    assign unit_en     = r_unit_en;
    assign ovf_err     = r_ovf;

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef LOG2_ADAPTER_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = s_valid & ~w_s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else if (perf_clr) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_issue && (r_perf_issued != '1)) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

    // ------------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------------
    // Every unit result must correspond to an issue exactly PIPE_LAT cycles
    // earlier.
    a_unit_latency : assert property (@(posedge clk) disable iff (rst)
        unit_vld_out |-> $past(unit_vld_in, PIPE_LAT));

    // Credits must keep the FIFO from ever overflowing.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop));

    a_credit_range : assert property (@(posedge clk) disable iff (rst)
        r_credit <= CredMax);

    // A result that is held must not change while it waits.
    a_m_hold : assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_log2_stream_adapter.sv
// ----------------------------------------------------------------------------
// Directed bench for log2_stream_adapter.
//
// A behavioural stand-in for the log2 unit (PIPE_LAT = 6) is built here. It is
// exact for powers of two and passes through the special values. Operands come
// from a table whose results were worked out by hand. Expected results are
// queued at each handshake and compared in order at each pop.
// ----------------------------------------------------------------------------
module tb_log2_stream_adapter;

    localparam int DW       = 32;
    localparam int DEPTH    = 8;
    localparam int PIPE_LAT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [DW-1:0] unit_op;
    logic          unit_vld_in;
    logic          unit_en;
    logic [DW-1:0] unit_result;
    logic          unit_vld_out;
    logic          ovf_err;
`ifdef LOG2_ADAPTER_PERF_EN
    logic          perf_clr = 1'b0;
    logic [31:0]   perf_issued;
    logic [31:0]   perf_stall;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int n_pops = 0;
    int op_idx = 0;

    logic [31:0] in_tab  [16];
    logic [31:0] out_tab [16];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    log2_stream_adapter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .PIPE_LAT   (PIPE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .unit_op      (unit_op),
        .unit_vld_in  (unit_vld_in),
        .unit_en      (unit_en),
        .unit_result  (unit_result),
        .unit_vld_out (unit_vld_out),
        .ovf_err      (ovf_err)
`ifdef LOG2_ADAPTER_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall)
`endif
    );

    // ---------------- behavioural log2 unit ----------------
    function automatic logic [31:0] int_to_fp(input int e);
        logic [31:0] r;
        logic [31:0] tmp;
        int          m;
        int          p;
        if (e == 0) return 32'h0;
        m = (e < 0) ? -e : e;
        p = 0;
        for (int b = 0; b < 8; b++) if (((m >> b) & 1) == 1) p = b;
        tmp       = 32'(m) << (23 - p);
        r[31]     = (e < 0);
        r[30:23]  = 8'(127 + p);
        r[22:0]   = tmp[22:0];
        return r;
    endfunction

    function automatic logic [31:0] log2_model(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return x;
        if (x[30:23] == 8'h00) return 32'hFF80_0000;
        if (x[31])             return 32'h7FC0_0000;
        return int_to_fp(int'(x[30:23]) - 127);
    endfunction

    logic [PIPE_LAT-1:0] u_vld;
    logic [31:0]         u_dat [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) u_dat[i] <= '0;
        end else begin
            u_vld    <= {u_vld[PIPE_LAT-2:0], unit_vld_in};
            u_dat[0] <= log2_model(unit_op);
            for (int i = 1; i < PIPE_LAT; i++) u_dat[i] <= u_dat[i-1];
        end
    end

    assign unit_vld_out = u_vld[PIPE_LAT-1];
    assign unit_result  = u_dat[PIPE_LAT-1];

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i);
        op_idx = i;
        s_data = in_tab[i % 16];
    endtask

    // Scoreboard one clock: record handshakes and pops that the upcoming edge
    // commits, then advance to just after the edge.
    task automatic cycle();
        bit hs;
        bit pp;
        hs = s_valid && s_ready;
        pp = m_valid && m_ready;
        if (pp) begin
            n_pops++;
            if (exp_q.size() == 0) check("pop_unexpected", 32'(m_valid), 32'd0);
            else                   check("pop_data", m_data, exp_q.pop_front());
        end
        if (hs) begin
            exp_q.push_back(out_tab[op_idx % 16]);
            op_idx++;
        end
        @(posedge clk);
        #1;
        s_data = in_tab[op_idx % 16];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int acc;
        int pairs;
        int guard;
        int stale;
        int pops0;

        in_tab  = '{32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 32'h4180_0000,
                    32'h4200_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h4480_0000,
                    32'h4280_0000, 32'h4300_0000, 32'h4380_0000, 32'h3E00_0000,
                    32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0001};
        out_tab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                    32'h40A0_0000, 32'hBF80_0000, 32'hC000_0000, 32'h4120_0000,
                    32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'hC040_0000,
                    32'hFF80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0001};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_unit_op", unit_op, 32'd0);
        check("rst_unit_vld_in", 32'(unit_vld_in), 32'd0);
        check("rst_unit_en", 32'(unit_en), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_unit_en", 32'(unit_en), 32'd1);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_credit", 32'(dut.r_credit), 32'd8);

        // ---- T1: single op 8.0 -> 3.0, latency 8 ----
        m_ready = 1'b1;
        set_op(2);
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        check("t1_vld_in", 32'(unit_vld_in), 32'd1);
        check("t1_unit_op", unit_op, 32'h4100_0000);
        cycle();
        n = 1;
        check("t1_vld_in_drop", 32'(unit_vld_in), 32'd0);
        check("t1_unit_op_hold", unit_op, 32'h4100_0000);
        while (!m_valid && n < 20) begin
            cycle();
            n++;
        end
        check("t1_latency", 32'(n + 1), 32'd8);
        check("t1_m_data", m_data, 32'h4040_0000);
        cycle();
        check("t1_credit_back", 32'(dut.r_credit), 32'd8);
        check("t1_m_valid_low", 32'(m_valid), 32'd0);

        // ---- T2: backpressure, 12 ops with m_ready=0 ----
        m_ready = 1'b0;
        set_op(0);
        s_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) check("t2_s_ready_9th", 32'(s_ready), 32'd0);
            if (s_ready) acc++;
            cycle();
        end
        check("t2_accepted", 32'(acc), 32'd8);
        s_valid = 1'b0;
        repeat (8) cycle();
        check("t2_full_m_valid", 32'(m_valid), 32'd1);
        check("t2_full_credit", 32'(dut.r_credit), 32'd0);
        check("t2_full_s_ready", 32'(s_ready), 32'd0);
        check("t2_ovf", 32'(ovf_err), 32'd0);
        pops0 = n_pops;
        m_ready = 1'b1;
        for (guard = 0; guard < 200; guard++) begin
            if (op_idx >= 12 && exp_q.size() == 0) break;
            s_valid = (op_idx < 12);
            cycle();
        end
        s_valid = 1'b0;
        check("t2_delivered", 32'(n_pops - pops0), 32'd12);
        check("t2_ovf_end", 32'(ovf_err), 32'd0);

        // ---- T3: issue+pop together at credit==1 ----
        m_ready = 1'b0;
        set_op(0);
        s_valid = 1'b1;
        repeat (8) cycle();
        s_valid = 1'b0;
        repeat (10) cycle();
        check("t3_credit0", 32'(dut.r_credit), 32'd0);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        check("t3_credit1", 32'(dut.r_credit), 32'd1);
        pairs = 0;
        for (guard = 0; guard < 200 && pairs < 20; guard++) begin
            if (m_valid) begin
                s_valid = 1'b1;
                m_ready = 1'b1;
                check("t3_pair_credit", 32'(dut.r_credit), 32'd1);
                check("t3_pair_s_ready", 32'(s_ready), 32'd1);
                pairs++;
            end else begin
                s_valid = 1'b0;
                m_ready = 1'b0;
            end
            cycle();
        end
        check("t3_pairs", 32'(pairs), 32'd20);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (guard = 0; guard < 50 && exp_q.size() != 0; guard++) cycle();
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_credit_back", 32'(dut.r_credit), 32'd8);

        // ---- T4: 3*DEPTH ops, random m_ready ----
        set_op(0);
        for (guard = 0; guard < 600; guard++) begin
            if (op_idx >= 3 * DEPTH && exp_q.size() == 0) break;
            s_valid = (op_idx < 3 * DEPTH);
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        s_valid = 1'b0;
        check("t4_issued", 32'(op_idx), 32'(3 * DEPTH));
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("t4_credit", 32'(dut.r_credit), 32'd8);
        check("t4_ptrs_equal", 32'(dut.r_wr_ptr), 32'(dut.r_rd_ptr));
        check("t4_ovf", 32'(ovf_err), 32'd0);

        // ---- T5: special values ----
        m_ready = 1'b1;
        set_op(12);
        s_valid = 1'b1;
        for (guard = 0; guard < 20 && op_idx < 16; guard++) cycle();
        s_valid = 1'b0;
        for (guard = 0; guard < 30 && exp_q.size() != 0; guard++) cycle();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // ---- T6: reset with 4 in flight and 3 buffered ----
        m_ready = 1'b0;
        set_op(0);
        s_valid = 1'b1;
        repeat (3) cycle();
        s_valid = 1'b0;
        repeat (9) cycle();
        s_valid = 1'b1;
        repeat (4) cycle();
        s_valid = 1'b0;
        check("t6_pre_credit", 32'(dut.r_credit), 32'd1);
        check("t6_pre_m_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_s_ready", 32'(s_ready), 32'd0);
        check("t6_rst_vld_in", 32'(unit_vld_in), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_rst_s_ready_hold", 32'(s_ready), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_credit", 32'(dut.r_credit), 32'd8);
        check("t6_s_ready", 32'(s_ready), 32'd1);
`ifdef LOG2_ADAPTER_PERF_EN
        check("t6_perf_issued", perf_issued, 32'd0);
        check("t6_perf_stall", perf_stall, 32'd0);
`endif
        m_ready = 1'b1;
        stale = 0;
        repeat (15) begin
            if (m_valid) stale++;
            cycle();
        end
        check("t6_stale", 32'(stale), 32'd0);
        check("t6_ovf", 32'(ovf_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
